command_router: RTL and testbench

//  Parametrised byte-stream command decoder: frames opcode+payload from cmd_in, assembles the payload and

---
 rtl/command_router_pkg.sv | 10 +
 rtl/command_router_if.sv | 31 +++
 rtl/command_router_payload_assembler.sv | 36 +++
 rtl/command_router.sv | 186 ++++++++++++++++++
 tb/tb_command_router.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/command_router_pkg.sv
// Shared types and response codes for the command router slice.
package command_router_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t RESP_ERR_OPCODE  = 8'hE0;
  localparam byte_t RESP_ERR_TIMEOUT = 8'hE1;
  localparam byte_t RESP_ACK         = 8'hAC;

endpackage

// File: rtl/command_router_if.sv
// Host byte stream, response stream and payload channels of the command router.
// All streams use valid/ready: a beat transfers on a clock edge where both are high;
// the source holds data stable while valid is high and ready is low.
interface command_router_if #(
  parameter int NUM_CH            = 4,
  parameter int MAX_PAYLOAD_BYTES = 32
) ();
  import command_router_pkg::*;

  logic                           cmd_in_valid;
  logic                           cmd_in_ready;
  byte_t                          cmd_in_data;
  logic                           cmd_out_valid;
  logic                           cmd_out_ready;
  byte_t                          cmd_out_data;
  logic [NUM_CH-1:0]              ch_valid;
  logic [NUM_CH-1:0]              ch_ready;
  logic [8*MAX_PAYLOAD_BYTES-1:0] ch_data;
  byte_t                          ch_ctx;

  modport master (
    output cmd_in_valid, cmd_in_data, cmd_out_ready, ch_ready,
    input  cmd_in_ready, cmd_out_valid, cmd_out_data, ch_valid, ch_data, ch_ctx
  );

  modport slave (
    input  cmd_in_valid, cmd_in_data, cmd_out_ready, ch_ready,
    output cmd_in_ready, cmd_out_valid, cmd_out_data, ch_valid, ch_data, ch_ctx
  );

endinterface

// File: rtl/command_router_payload_assembler.sv
// Byte counter plus payload register; byte k of a frame lands in data[8k+:8].
module command_router_payload_assembler
  import command_router_pkg::*;
#(
  parameter  int MAX_PAYLOAD_BYTES = 32,
  localparam int CW                = $clog2(MAX_PAYLOAD_BYTES + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           load,
  input  byte_t                          din,
  input  logic [CW-1:0]                  len,
  output logic                           done,
  output logic [8*MAX_PAYLOAD_BYTES-1:0] data
);

  logic [CW-1:0] count;

  // High when the next loaded byte completes a payload of length len.
  assign done = (count + CW'(1)) == len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      data  <= '0;
    end else if (clear) begin
      count <= '0;
      data  <= '0;
    end else if (load) begin
      data[8*int'(count) +: 8] <= din;
      count                    <= count + CW'(1);
    end
  end

endmodule

// File: rtl/command_router.sv
// Byte-stream command decoder: frames opcode+payload and dispatches it on one of NUM_CH channels.
// Define COMMAND_ROUTER_ACK_EN to answer each dispatch and SET_CONTEXT with an 8'hAC response.
module command_router
  import command_router_pkg::*;
#(
  parameter int    NUM_CH            = 4,
  parameter int    MAX_PAYLOAD_BYTES = 32,
  parameter byte_t CH_OPCODE [NUM_CH] = '{8'hA1, 8'hB0, 8'hC0, 8'hC1},
  parameter int    CH_LEN    [NUM_CH] = '{24, 20, 0, 4},
  parameter byte_t CTX_OPCODE        = 8'hA0,
  parameter int    TIMEOUT_CYCLES    = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  command_router_if.slave        bus,
  output logic [1:0]             dbg_state
);

  localparam int CW = $clog2(MAX_PAYLOAD_BYTES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
`ifdef COMMAND_ROUTER_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cfg_chk
    if (CH_LEN[i] > MAX_PAYLOAD_BYTES) begin : g_len
      $error("command_router: CH_LEN[%0d] exceeds MAX_PAYLOAD_BYTES", i);
    end
    if (CH_OPCODE[i] == CTX_OPCODE) begin : g_ctx
      $error("command_router: CH_OPCODE[%0d] collides with CTX_OPCODE", i);
    end
    for (genvar j = i + 1; j < NUM_CH; j++) begin : g_dup
      if (CH_OPCODE[i] == CH_OPCODE[j]) begin : g_same
        $error("command_router: CH_OPCODE[%0d] duplicates CH_OPCODE[%0d]", j, i);
      end
    end
  end

  typedef enum logic [1:0] {IDLE, PAYLOAD, DISPATCH, RESP} state_t;

  state_t        state_q, state_d;
  logic          is_ctx_q, is_ctx_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [CW-1:0] len_q, len_d;
  logic [TW-1:0] timer_q, timer_d;
  byte_t         resp_q, resp_d;
  byte_t         ctx_q, ctx_d;
  logic          asm_clear, asm_load, asm_done;
  logic          hit;
  logic [SW-1:0] hit_idx;
  logic [CW-1:0] hit_len;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_len = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.cmd_in_data == CH_OPCODE[i]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
        hit_len = CW'(CH_LEN[i]);
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    is_ctx_d          = is_ctx_q;
    sel_d             = sel_q;
    len_d             = len_q;
    timer_d           = timer_q;
    resp_d            = resp_q;
    ctx_d             = ctx_q;
    asm_clear         = 1'b0;
    asm_load          = 1'b0;
    bus.cmd_in_ready  = 1'b0;
    bus.cmd_out_valid = 1'b0;
    bus.ch_valid      = '0;
    case (state_q)
      IDLE: begin
        bus.cmd_in_ready = 1'b1;
        if (bus.cmd_in_valid) begin
          timer_d = '0;
          if (bus.cmd_in_data == CTX_OPCODE) begin
            is_ctx_d = 1'b1;
            state_d  = PAYLOAD;
          end else if (hit) begin
            is_ctx_d  = 1'b0;
            sel_d     = hit_idx;
            len_d     = hit_len;
            asm_clear = 1'b1;
            state_d   = (hit_len == '0) ? DISPATCH : PAYLOAD;
          end else begin
            resp_d  = RESP_ERR_OPCODE;
            state_d = RESP;
          end
        end
      end
      PAYLOAD: begin
        bus.cmd_in_ready = 1'b1;
        if (bus.cmd_in_valid) begin
          timer_d  = '0;
          asm_load = !is_ctx_q;
          // SET_CONTEXT carries a single byte and never touches the channel payload.
          if (is_ctx_q) begin
            ctx_d = bus.cmd_in_data;
            if (ACK_EN) begin
              resp_d  = RESP_ACK;
              state_d = RESP;
            end else begin
              state_d = IDLE;
            end
          end else if (asm_done) begin
            state_d = DISPATCH;
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          if (timer_q == TIMER_LAST) begin
            asm_clear = 1'b1;
            resp_d    = RESP_ERR_TIMEOUT;
            state_d   = RESP;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      DISPATCH: begin
        bus.ch_valid = NUM_CH'(1) << sel_q;
        if (bus.ch_ready[sel_q]) begin
          if (ACK_EN) begin
            resp_d  = RESP_ACK;
            state_d = RESP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RESP: begin
        bus.cmd_out_valid = 1'b1;
        if (bus.cmd_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      is_ctx_q <= 1'b0;
      sel_q    <= '0;
      len_q    <= '0;
      timer_q  <= '0;
      resp_q   <= '0;
      ctx_q    <= '0;
    end else begin
      state_q  <= state_d;
      is_ctx_q <= is_ctx_d;
      sel_q    <= sel_d;
      len_q    <= len_d;
      timer_q  <= timer_d;
      resp_q   <= resp_d;
      ctx_q    <= ctx_d;
    end
  end

  command_router_payload_assembler #(
    .MAX_PAYLOAD_BYTES (MAX_PAYLOAD_BYTES)
  ) u_asm (
    .clk   (clk),
    .rst   (rst),
    .clear (asm_clear),
    .load  (asm_load),
    .din   (bus.cmd_in_data),
    .len   (len_q),
    .done  (asm_done),
    .data  (bus.ch_data)
  );

  assign bus.cmd_out_data = resp_q;
  assign bus.ch_ctx       = ctx_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_command_router.sv
// Directed bench for command_router with a frame-level reference model checked every cycle.
module tb_command_router;
  import command_router_pkg::*;

  localparam int    TIMEOUT = 16;
  localparam byte_t CTX_OP  = 8'hA0;
  localparam byte_t M_OPC [4] = '{8'hA1, 8'hB0, 8'hC0, 8'hC1};
  localparam int    M_LEN [4] = '{24, 20, 0, 4};
`ifdef COMMAND_ROUTER_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  command_router_if #(.NUM_CH(4), .MAX_PAYLOAD_BYTES(32)) bus ();

  command_router #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_COLLECT, M_OFFER, M_RESP} mode_t;

  mode_t        m_mode;
  int           m_target;
  int           m_need;
  int           m_idle;
  byte_t        pay [$];
  logic [255:0] m_data;
  byte_t        m_ctx;
  byte_t        m_out;
  logic [3:0]   exp_valid;

  function automatic int lookup(input byte_t b);
    for (int i = 0; i < 4; i++) if (M_OPC[i] == b) return i;
    return -1;
  endfunction

  task automatic frame_done();
    if (ACK) begin
      m_out  = 8'hAC;
      m_mode = M_RESP;
    end else begin
      m_mode = M_IDLE;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE; m_target = 0; m_need = 0; m_idle = 0;
      pay.delete(); m_data = '0; m_ctx = '0; m_out = '0;
    end else begin
      case (m_mode)
        M_IDLE: if (bus.cmd_in_valid) begin
          m_idle = 0;
          pay.delete();
          if (bus.cmd_in_data == CTX_OP) begin
            m_target = -1; m_need = 1; m_mode = M_COLLECT;
          end else if (lookup(bus.cmd_in_data) >= 0) begin
            m_target = lookup(bus.cmd_in_data);
            m_need   = M_LEN[m_target];
            m_data   = '0;
            m_mode   = (m_need == 0) ? M_OFFER : M_COLLECT;
          end else begin
            m_out = 8'hE0; m_mode = M_RESP;
          end
        end
        M_COLLECT: if (bus.cmd_in_valid) begin
          m_idle = 0;
          pay.push_back(bus.cmd_in_data);
          if (pay.size() == m_need) begin
            if (m_target < 0) begin
              m_ctx = pay[0];
              frame_done();
            end else begin
              for (int k = 0; k < pay.size(); k++) m_data[8*k +: 8] = pay[k];
              m_mode = M_OFFER;
            end
          end
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT) begin
            pay.delete(); m_out = 8'hE1; m_mode = M_RESP;
          end
        end
        M_OFFER: if (bus.ch_ready[m_target]) frame_done();
        M_RESP:  if (bus.cmd_out_ready) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // Compare process: outputs are meaningful on every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      exp_valid = (m_mode == M_OFFER) ? 4'(1 << m_target) : 4'b0;
      check("cmp_in_ready", bus.cmd_in_ready, (m_mode == M_IDLE) || (m_mode == M_COLLECT));
      check("cmp_ch_valid", bus.ch_valid, exp_valid);
      check("cmp_out_valid", bus.cmd_out_valid, m_mode == M_RESP);
      check("cmp_out_data", bus.cmd_out_data, m_out);
      check("cmp_ch_ctx", bus.ch_ctx, m_ctx);
      if (m_mode == M_OFFER) check("cmp_ch_data", bus.ch_data, m_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input byte_t b);
    logic done;
    done = 1'b0;
    bus.cmd_in_valid = 1'b1;
    bus.cmd_in_data  = b;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = bus.cmd_in_ready;
      @(posedge clk);
      #1;
    end
    bus.cmd_in_valid = 1'b0;
    check("send_accept", done, 1'b1);
  endtask

  task automatic send_frame(input byte_t op, input int n, input byte_t base);
    send_byte(op);
    for (int k = 0; k < n; k++) send_byte(byte_t'(base + k));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ch_valid"}, bus.ch_valid, 4'b0);
    check({tag, "_out_valid"}, bus.cmd_out_valid, 1'b0);
    check({tag, "_out_data"}, bus.cmd_out_data, 8'h00);
    check({tag, "_ch_data"}, bus.ch_data, 256'h0);
    check({tag, "_ch_ctx"}, bus.ch_ctx, 8'h00);
    check({tag, "_state"}, dbg_state, 2'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1;
    bus.cmd_in_valid  = 1'b0;
    bus.cmd_in_data   = 8'h00;
    bus.cmd_out_ready = 1'b1;
    bus.ch_ready      = 4'b1111;
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #1 rst = 1'b0;

    // 1: channel 0 full-length frame
    send_frame(8'hA1, 24, 8'h01);
    @(negedge clk);
    check("t1_valid", bus.ch_valid, 4'b0001);
    check("t1_b0", bus.ch_data[7:0], 8'h01);
    check("t1_b23", bus.ch_data[191:184], 8'h18);
    check("t1_upper", bus.ch_data[255:192], 64'h0);
    @(posedge clk); #1;

    // 2: context then channel 1 under backpressure
    bus.ch_ready[1] = 1'b0;
    send_byte(CTX_OP);
    send_byte(8'h07);
    send_frame(8'hB0, 20, 8'h40);
    @(negedge clk);
    check("t2_valid", bus.ch_valid, 4'b0010);
    check("t2_ctx", bus.ch_ctx, 8'h07);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("t2_hold_valid", bus.ch_valid, 4'b0010);
      check("t2_hold_ready", bus.cmd_in_ready, 1'b0);
      check("t2_hold_b19", bus.ch_data[159:152], 8'h53);
    end
    bus.ch_ready[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_released", bus.ch_valid, 4'b0000);
    @(posedge clk); #1;

    // 3: unknown opcode with a stalled response consumer
    bus.cmd_out_ready = 1'b0;
    send_byte(8'h55);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_valid", bus.cmd_out_valid, 1'b1);
      check("t3_code", bus.cmd_out_data, 8'hE0);
      check("t3_ready", bus.cmd_in_ready, 1'b0);
      @(posedge clk);
    end
    #1 bus.cmd_out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_idle_ready", bus.cmd_in_ready, 1'b1);
    check("t3_idle_valid", bus.cmd_out_valid, 1'b0);
    @(posedge clk); #1;

    // 4: inter-byte timeout, then a clean frame
    send_frame(8'hA1, 3, 8'h90);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      check("t4_wait", bus.cmd_out_valid, 1'b0);
      @(posedge clk);
    end
    #1;
    @(negedge clk);
    check("t4_valid", bus.cmd_out_valid, 1'b1);
    check("t4_code", bus.cmd_out_data, 8'hE1);
    check("t4_no_ch", bus.ch_valid, 4'b0000);
    @(posedge clk); #1;
    send_frame(8'hA1, 24, 8'hC0);
    @(negedge clk);
    check("t4_again_valid", bus.ch_valid, 4'b0001);
    check("t4_again_b0", bus.ch_data[7:0], 8'hC0);
    check("t4_again_b23", bus.ch_data[191:184], 8'hD7);
    @(posedge clk); #1;

    // 5: zero-length channel
    send_byte(8'hC0);
    @(negedge clk);
    check("t5_valid", bus.ch_valid, 4'b0100);
    check("t5_data", bus.ch_data, 256'h0);
    @(posedge clk); #1;
`ifdef COMMAND_ROUTER_ACK_EN
    @(negedge clk);
    check("t5_ack_valid", bus.cmd_out_valid, 1'b1);
    check("t5_ack_code", bus.cmd_out_data, 8'hAC);
    @(posedge clk); #1;
`endif

    // 6: reset mid-payload, then a full frame on channel 3
    send_frame(8'hB0, 5, 8'h11);
    rst = 1'b1;
    #1;
    check_reset("t6");
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    send_frame(8'hC1, 4, 8'hE5);
    @(negedge clk);
    check("t6_valid", bus.ch_valid, 4'b1000);
    check("t6_data", bus.ch_data, 256'hE8E7E6E5);
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
